// File: rtl/efuse_shadow_loader.sv
// efuse_shadow_loader
// Captures the eFuse controller's autoload byte stream into an NB-byte shadow
// register file. Once autoload completes it verifies completeness and an
// additive checksum, then presents the verified trim bus to analog/PMU
// consumers.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   pmu_efuse_start          autoload start / abort-and-restart pulse
//   efuse_autoload_vld       strobe qualifying efuse_ld_addr / efuse_ld_data
//   efuse_autoload_done      controller finished autoload
//   rg_efuse_timeout         LOAD cycle limit (0 = no limit)
//   rg_shadow_rd_addr/data   registered byte readback (1-cycle latency)
//   rg_shadow_wr_*           post-load software patch (DONE/ERR only)
//   trim_bus                 shadow contents when verified, else TRIM_DEF
//   shadow_valid/shadow_err  verification status
//   err_code                 {timeout, chksum_mismatch, missing_byte}
//   addr_err                 out-of-range load address seen
//   loader_busy              LOAD or CHECK in progress
//
// state | meaning
// IDLE  | waiting for the first start pulse
// LOAD  | capturing autoload bytes, timeout counter running
// CHECK | summing bytes 0..NB-2 one per cycle
// EVAL  | comparing mask and checksum, choosing DONE or ERR
// DONE  | shadow verified, trim bus live, patching allowed
// ERR   | verification failed, trim bus at default, patching allowed
module efuse_shadow_loader #(
   parameter  int              NB       = 32,
   parameter  int              TO_W     = 16,
   parameter  logic [7:0]      CHK_INIT = 8'h5A,
   parameter  logic [NB*8-1:0] TRIM_DEF = '0,
   localparam int              AW       = $clog2(NB)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pmu_efuse_start,
   input  logic            efuse_autoload_vld,
   input  logic [7:0]      efuse_ld_addr,
   input  logic [7:0]      efuse_ld_data,
   input  logic            efuse_autoload_done,
   input  logic [TO_W-1:0] rg_efuse_timeout,
   input  logic [AW-1:0]   rg_shadow_rd_addr,
   output logic [7:0]      rg_shadow_rd_data,
   input  logic            rg_shadow_wr_en,
   input  logic [AW-1:0]   rg_shadow_wr_addr,
   input  logic [7:0]      rg_shadow_wr_data,
   output logic [NB*8-1:0] trim_bus,
   output logic            shadow_valid,
   output logic            shadow_err,
   output logic [2:0]      err_code,
   output logic            addr_err,
   output logic            loader_busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_EVAL, S_DONE, S_ERR
   } state_t;

   localparam logic [8:0]    NB_L     = 9'(NB);
   localparam logic [AW-1:0] LAST_IDX = AW'(NB - 2);

   state_t          state;
   logic [7:0]      shadow [NB];
   logic [NB-1:0]   recv_mask;
   logic [TO_W-1:0] cnt;
   logic [TO_W-1:0] cnt_nxt;
   logic [7:0]      acc;
   logic [AW-1:0]   idx;
   logic            in_range;
   logic            miss;
   logic            bad_sum;
   logic [NB*8-1:0] shadow_flat;

   assign cnt_nxt  = cnt + TO_W'(1);
   assign in_range = ({1'b0, efuse_ld_addr} < NB_L);
   assign miss     = ~&recv_mask;
   assign bad_sum  = (acc != shadow[NB-1]);

   always_comb begin
      shadow_flat = '0;
      for (int i = 0; i < NB; i++) shadow_flat[i*8 +: 8] = shadow[i];
   end

   // Combinational from the shadow so a patch in DONE shows on the next cycle.
   assign trim_bus    = shadow_valid ? shadow_flat : TRIM_DEF;
   assign loader_busy = (state == S_LOAD) || (state == S_CHECK);

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         for (int i = 0; i < NB; i++) shadow[i] <= '0;
         recv_mask         <= '0;
         cnt               <= '0;
         acc               <= '0;
         idx               <= '0;
         err_code          <= '0;
         addr_err          <= 1'b0;
         shadow_valid      <= 1'b0;
         shadow_err        <= 1'b0;
         rg_shadow_rd_data <= '0;
      end else begin
         rg_shadow_rd_data <= shadow[rg_shadow_rd_addr];
         if (pmu_efuse_start) begin
            // Start aborts whatever is in flight and restarts from a clean slate.
            for (int i = 0; i < NB; i++) shadow[i] <= '0;
            recv_mask    <= '0;
            cnt          <= '0;
            acc          <= '0;
            idx          <= '0;
            err_code     <= '0;
            addr_err     <= 1'b0;
            shadow_valid <= 1'b0;
            shadow_err   <= 1'b0;
            state        <= S_LOAD;
         end else begin
            case (state)
               S_IDLE: ;
               S_LOAD: begin
                  if (efuse_autoload_vld) begin
                     if (in_range) begin
                        shadow[efuse_ld_addr[AW-1:0]]    <= efuse_ld_data;
                        recv_mask[efuse_ld_addr[AW-1:0]] <= 1'b1;
                     end else begin
                        addr_err <= 1'b1;
                     end
                  end
                  cnt <= cnt_nxt;
                  // done beats a timeout landing on the same cycle
                  if (efuse_autoload_done) begin
                     idx   <= '0;
                     acc   <= CHK_INIT;
                     state <= S_CHECK;
                  end else if ((rg_efuse_timeout != '0) && (cnt_nxt == rg_efuse_timeout)) begin
                     err_code[2] <= 1'b1;
                     shadow_err  <= 1'b1;
                     state       <= S_ERR;
                  end
               end
               S_CHECK: begin
                  acc <= acc + shadow[idx];
                  idx <= idx + AW'(1);
                  if (idx == LAST_IDX) state <= S_EVAL;
               end
               S_EVAL: begin
                  err_code[1:0] <= {bad_sum, miss};
                  if (miss || bad_sum) begin
                     shadow_err <= 1'b1;
                     state      <= S_ERR;
                  end else begin
                     shadow_valid <= 1'b1;
                     state        <= S_DONE;
                  end
               end
               S_DONE, S_ERR: begin
                  if (rg_shadow_wr_en) shadow[rg_shadow_wr_addr] <= rg_shadow_wr_data;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_efuse_shadow_loader.sv
module tb_efuse_shadow_loader;

   localparam int NB = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            pmu_efuse_start;
   logic            efuse_autoload_vld;
   logic [7:0]      efuse_ld_addr;
   logic [7:0]      efuse_ld_data;
   logic            efuse_autoload_done;
   logic [15:0]     rg_efuse_timeout;
   logic [4:0]      rg_shadow_rd_addr;
   logic [7:0]      rg_shadow_rd_data;
   logic            rg_shadow_wr_en;
   logic [4:0]      rg_shadow_wr_addr;
   logic [7:0]      rg_shadow_wr_data;
   logic [NB*8-1:0] trim_bus;
   logic            shadow_valid;
   logic            shadow_err;
   logic [2:0]      err_code;
   logic            addr_err;
   logic            loader_busy;

   int n_chk = 0;
   int n_err = 0;
   int cyc;

   efuse_shadow_loader dut (
      .clk                 (clk),
      .rst                 (rst),
      .pmu_efuse_start     (pmu_efuse_start),
      .efuse_autoload_vld  (efuse_autoload_vld),
      .efuse_ld_addr       (efuse_ld_addr),
      .efuse_ld_data       (efuse_ld_data),
      .efuse_autoload_done (efuse_autoload_done),
      .rg_efuse_timeout    (rg_efuse_timeout),
      .rg_shadow_rd_addr   (rg_shadow_rd_addr),
      .rg_shadow_rd_data   (rg_shadow_rd_data),
      .rg_shadow_wr_en     (rg_shadow_wr_en),
      .rg_shadow_wr_addr   (rg_shadow_wr_addr),
      .rg_shadow_wr_data   (rg_shadow_wr_data),
      .trim_bus            (trim_bus),
      .shadow_valid        (shadow_valid),
      .shadow_err          (shadow_err),
      .err_code            (err_code),
      .addr_err            (addr_err),
      .loader_busy         (loader_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [NB*8-1:0] obs, input logic [NB*8-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      pmu_efuse_start = 1'b1;
      tick();
      pmu_efuse_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] d, input logic with_done);
      efuse_autoload_vld  = 1'b1;
      efuse_ld_addr       = a;
      efuse_ld_data       = d;
      efuse_autoload_done = with_done;
      tick();
      efuse_autoload_vld  = 1'b0;
      efuse_autoload_done = 1'b0;
   endtask

   task automatic send_done();
      efuse_autoload_done = 1'b1;
      tick();
      efuse_autoload_done = 1'b0;
   endtask

   // Bytes 0..NB-2 = 8'h01, last byte = last; skip < 0 loads every address.
   task automatic load_all(input int skip, input logic [7:0] last, input logic merge_done);
      for (int a = 0; a < NB - 1; a++)
         if (a != skip) send(8'(a), 8'h01, 1'b0);
      send(8'(NB - 1), last, merge_done);
      if (!merge_done) send_done();
   endtask

   task automatic wait_result(output int n);
      n = 0;
      while (!(shadow_valid || shadow_err) && n < 300) begin
         tick();
         n++;
      end
      check("result_wait_expired", 256'(n >= 300), 256'(0));
   endtask

   task automatic read_byte(input logic [4:0] a, output logic [7:0] d);
      rg_shadow_rd_addr = a;
      tick();
      d = rg_shadow_rd_data;
   endtask

   logic [7:0] rd;

   initial begin
      rst = 1'b1;
      pmu_efuse_start = 1'b0;
      efuse_autoload_vld = 1'b0;
      efuse_ld_addr = '0;
      efuse_ld_data = '0;
      efuse_autoload_done = 1'b0;
      rg_efuse_timeout = '0;
      rg_shadow_rd_addr = '0;
      rg_shadow_wr_en = 1'b0;
      rg_shadow_wr_addr = '0;
      rg_shadow_wr_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check("rst_valid", 256'(shadow_valid), 256'(0));
      check("rst_err", 256'(shadow_err), 256'(0));
      check("rst_err_code", 256'(err_code), 256'(0));
      check("rst_addr_err", 256'(addr_err), 256'(0));
      check("rst_busy", 256'(loader_busy), 256'(0));
      check("rst_trim", trim_bus, 256'(0));
      check("rst_rd_data", 256'(rg_shadow_rd_data), 256'(0));

      // Full load; patch attempt during LOAD must be ignored.
      do_start();
      check("load_busy", 256'(loader_busy), 256'(1));
      rg_shadow_wr_en = 1'b1; rg_shadow_wr_addr = 5'd0; rg_shadow_wr_data = 8'h55;
      tick();
      rg_shadow_wr_en = 1'b0;
      read_byte(5'd0, rd);
      check("patch_in_load_ignored", 256'(rd), 256'(0));
      for (int a = 0; a < NB - 1; a++) send(8'(a), 8'h01, 1'b0);
      send(8'd31, 8'h79, 1'b0);
      efuse_autoload_done = 1'b1;
      tick();
      efuse_autoload_done = 1'b0;
      check("check_busy", 256'(loader_busy), 256'(1));
      wait_result(cyc);
      check("full_check_latency", 256'(cyc), 256'(32));
      check("full_valid", 256'(shadow_valid), 256'(1));
      check("full_err_code", 256'(err_code), 256'(0));
      check("full_trim_lo", 256'(trim_bus[7:0]), 256'(8'h01));
      check("full_trim_hi", 256'(trim_bus[255:248]), 256'(8'h79));
      check("full_busy_drop", 256'(loader_busy), 256'(0));
      read_byte(5'd31, rd);
      check("full_readback31", 256'(rd), 256'(8'h79));

      // Patch in DONE.
      rg_shadow_wr_en = 1'b1; rg_shadow_wr_addr = 5'd0; rg_shadow_wr_data = 8'hAA;
      rg_shadow_rd_addr = 5'd0;
      tick();
      rg_shadow_wr_en = 1'b0;
      check("patch_trim", 256'(trim_bus[7:0]), 256'(8'hAA));
      check("patch_keeps_valid", 256'(shadow_valid), 256'(1));
      tick();
      check("patch_readback", 256'(rg_shadow_rd_data), 256'(8'hAA));

      // Start in DONE clears status.
      do_start();
      check("restart_clears_valid", 256'(shadow_valid), 256'(0));
      check("restart_trim_default", trim_bus, 256'(0));

      // Checksum mismatch.
      load_all(-1, 8'h78, 1'b0);
      wait_result(cyc);
      check("csum_err", 256'(shadow_err), 256'(1));
      check("csum_err_code", 256'(err_code), 256'(3'b010));
      check("csum_trim_default", trim_bus, 256'(0));

      // Missing byte 5 with adjusted checksum.
      do_start();
      load_all(5, 8'h78, 1'b0);
      wait_result(cyc);
      check("miss_err", 256'(shadow_err), 256'(1));
      check("miss_err_code", 256'(err_code), 256'(3'b001));

      // Timeout of 100 LOAD cycles.
      rg_efuse_timeout = 16'd100;
      do_start();
      cyc = 0;
      while (!shadow_err && cyc < 300) begin
         tick();
         cyc++;
      end
      check("timeout_cycles", 256'(cyc), 256'(100));
      check("timeout_err_code", 256'(err_code), 256'(3'b100));
      check("timeout_busy_drop", 256'(loader_busy), 256'(0));
      rg_efuse_timeout = 16'd0;

      // Restart mid-load leaves no residue.
      do_start();
      for (int a = 0; a < 10; a++) send(8'(a), 8'hEE, 1'b0);
      do_start();
      read_byte(5'd3, rd);
      check("restart_no_residue", 256'(rd), 256'(0));
      load_all(-1, 8'h79, 1'b0);
      wait_result(cyc);
      check("restart_valid", 256'(shadow_valid), 256'(1));
      check("restart_err_code", 256'(err_code), 256'(0));
      read_byte(5'd3, rd);
      check("restart_byte3", 256'(rd), 256'(8'h01));

      // Out-of-range address, then done merged with the last byte.
      do_start();
      send(8'h40, 8'hFF, 1'b0);
      check("addr_err_set", 256'(addr_err), 256'(1));
      read_byte(5'd0, rd);
      check("addr_err_shadow_unchanged", 256'(rd), 256'(0));
      load_all(-1, 8'h79, 1'b1);
      wait_result(cyc);
      check("merged_done_valid", 256'(shadow_valid), 256'(1));
      check("merged_done_err_code", 256'(err_code), 256'(0));
      check("merged_byte31", 256'(trim_bus[255:248]), 256'(8'h79));
      check("addr_err_sticky", 256'(addr_err), 256'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/efuse_shadow_loader.md
Name: efuse_shadow_loader

Overview:
- Downstream consumer of the eFuse controller's autoload stream.
- Captures each autoloaded byte into an NB-byte shadow register file and verifies completeness and an additive checksum once autoload finishes.
- Presents the verified trim bus to analog/PMU consumers, with a parameterised default when data are not verified.
- Also provides a register readback port and a post-load software patch port.

Parameters:
- NB, 32, shadow depth in bytes (covers 256 fuse bits); last byte NB-1 holds the checksum.
- TO_W, 16, width of the autoload timeout counter.
- CHK_INIT, 8'h5A, checksum seed.
- TRIM_DEF, {NB*8{1'b0}}, trim bus value driven while not verified.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pmu_efuse_start  in  1  autoload start pulse (same pulse given to the controller)
- efuse_autoload_vld  in  1  one-cycle strobe: efuse_ld_addr/efuse_ld_data are valid
- efuse_ld_addr  in  8  byte address of the loaded byte
- efuse_ld_data  in  8  loaded byte
- efuse_autoload_done  in  1  one-cycle pulse: controller finished autoload
- rg_efuse_timeout  in  TO_W  maximum LOAD cycles; 0 disables the timeout
- rg_shadow_rd_addr  in  $clog2(NB)  readback byte select
- rg_shadow_rd_data  out  8  readback byte, 1-cycle latency
- rg_shadow_wr_en  in  1  software patch strobe
- rg_shadow_wr_addr  in  $clog2(NB)  patch byte address
- rg_shadow_wr_data  in  8  patch byte
- trim_bus  out  NB*8  shadow contents if shadow_valid, else TRIM_DEF
- shadow_valid  out  1  load verified
- shadow_err  out  1  load failed
- err_code  out  3  {timeout, chksum_mismatch, missing_byte}; sticky until next start
- addr_err  out  1  sticky: a vld arrived with efuse_ld_addr >= NB
- loader_busy  out  1  high in LOAD or CHECK

Behaviour:
- Reset values:
  - All outputs 0, except trim_bus = TRIM_DEF.
  - Shadow bytes 0, recv_mask 0, state IDLE.
- States:
  - IDLE: waits for pmu_efuse_start.
  - LOAD:
    - Each vld with addr < NB writes shadow[addr] and sets recv_mask[addr]; a duplicate address overwrites the byte.
    - A vld with addr >= NB is dropped and sets addr_err.
    - Cycle counter increments each LOAD cycle. If rg_efuse_timeout != 0 and counter == rg_efuse_timeout → ERR with err_code[2].
    - efuse_autoload_done → CHECK.
    - vld and done in the same cycle: the byte is captured, then transition to CHECK.
  - CHECK:
    - Iterates idx = 0..NB-2, one byte per cycle: acc = acc + shadow[idx] (mod 256), acc seeded with CHK_INIT. Takes NB-1 cycles.
    - On the following cycle, evaluates:
      - recv_mask != all-ones → err_code[0].
      - acc != shadow[NB-1] → err_code[1].
      - Any error bit set → ERR; none set → DONE.
    - vld strobes during CHECK are ignored.
  - DONE: shadow_valid = 1, shadow_err = 0.
  - ERR: shadow_valid = 0, shadow_err = 1.
  - DONE and ERR hold until the next start.
- pmu_efuse_start in any state, including mid-LOAD or mid-CHECK:
  - Aborts the current operation.
  - Clears shadow, recv_mask, counter, acc, err_code, addr_err, shadow_valid and shadow_err.
  - Enters LOAD on the next cycle.
- Status timing: shadow_valid and shadow_err are registered and assert on the cycle after the decision.
- Software patch:
  - rg_shadow_wr_en writes shadow[wr_addr] only in DONE or ERR; ignored in IDLE, LOAD and CHECK.
  - Does not alter status or re-run the check.
  - In DONE, trim_bus reflects the patch on the next cycle.
- Readback: rg_shadow_rd_data = shadow[rd_addr] registered; available in every state.
- loader_busy = (state == LOAD || state == CHECK).

Test Plan:
- Full load: start; 32 vld strobes, bytes 0..30 = 8'h01, byte 31 = 8'h79; then done → after 31 CHECK cycles + 1, shadow_valid = 1, err_code = 0, trim_bus[7:0] = 8'h01.
- Checksum fail: same as full load but byte 31 = 8'h78 → shadow_err = 1, err_code = 3'b010, trim_bus = TRIM_DEF.
- Missing byte: omit addr 5, checksum adjusted to 8'h78 → err_code = 3'b001, shadow_err = 1.
- Timeout: rg_efuse_timeout = 100, start, no done → ERR exactly 100 LOAD cycles after entry, err_code = 3'b100, loader_busy drops.
- Restart mid-load: start, 10 bytes, start again, full valid load → shadow_valid = 1, no residual bytes from the first attempt, err_code = 0.
- Edge strobes:
  - vld with addr = 8'h40 → addr_err = 1, shadow unchanged.
  - vld with done on byte 31 → byte 31 captured, check passes.
  - Patch byte 0 to 8'hAA in DONE → trim_bus[7:0] = 8'hAA, readback 8'hAA one cycle later.
